ras_stack: RTL and testbench
============================

// Module: ras_stack
// PURPOSE
//  Return address stack for the fetch stage. Consumes the one-per-bundle ras_ctrl / ras_data
//  produced by the branch decoder and keeps a circular LIFO of return addresses.
//  Drives the predicted return target back to the decoder (top_data_o).
//  Exports a checkpoint for each bundle and accepts a restore from execute on mispredict.
// PARAMETERS
//  DEPTH   8    number of stack entries (power of 2)
//  PTR_W   3    log2(DEPTH)
//  AW      64   address width
// PORTS
//  clk_i          in   1      clock; all state updates on rising edge
//  rst_i          in   1      synchronous, active-high reset
//  ras_valid_i    in   1      qualifies ras_ctrl_i (bundle accepted and branch exists)
//  ras_ctrl_i     in   2      00 none, 01 push (call), 10 pop (return), 11 pop+push (coroutine)
//  ras_data_i     in   AW     PC of the call/return instruction
//  recover_i      in   1      mispredict restore strobe
//  recover_tos_i  in   PTR_W  checkpointed top-of-stack pointer
//  recover_cnt_i  in   PTR_W+1 checkpointed occupancy
//  recover_top_i  in   AW     checkpointed top entry value
//  top_data_o     out  AW     mem[tos], predicted return target
//  ckpt_tos_o     out  PTR_W  current tos (pre-update) for the branch's checkpoint
//  ckpt_cnt_o     out  PTR_W+1 current occupancy (pre-update)
//  ckpt_top_o     out  AW     equals top_data_o
//  empty_o        out  1      cnt==0
//  underflow_o    out  1      1-cycle pulse: pop or pop+push applied while empty
// BEHAVIOUR
//  - State: mem[0..DEPTH-1], tos (PTR_W), cnt (0..DEPTH). Outputs are combinational from state;
//    an update is visible on top_data_o the cycle after the edge that applied it (latency 1).
//  - Reset: all mem=0, tos=0, cnt=0, so top_data_o=0, empty_o=1, underflow_o=0. Reset wins over
//    every other input and aborts any operation in flight.
//  - Push value is always ras_data_i+4 (AW-bit add, carry discarded).
//  - Priority per cycle: rst_i > recover_i > ras_valid_i. ras_valid_i with ctrl=00 is a no-op.
//  - push: tos<=tos+1 (mod DEPTH); mem[tos+1]<=data+4; cnt<=min(cnt+1,DEPTH).
//    Full (cnt==DEPTH): the oldest entry is overwritten silently, cnt stays DEPTH.
//  - pop: cnt>0 -> tos<=tos-1 (mod DEPTH), cnt<=cnt-1. cnt==0 -> no state change, underflow_o=1.
//    Popped entry contents are left in place (not cleared).
//  - pop+push: cnt>0 -> mem[tos]<=data+4; tos, cnt unchanged.
//    cnt==0 -> behaves as push and underflow_o=1.
//  - recover: tos<=recover_tos_i; cnt<=recover_cnt_i; mem[recover_tos_i]<=recover_top_i;
//    any same-cycle ras_valid_i op is dropped. underflow_o=0 that cycle.
//  - underflow_o is registered for one cycle only; it is 0 in every cycle with no qualifying event.
//  - recover_cnt_i > DEPTH is illegal and is clamped to DEPTH.
// TESTING
//  1 reset; push pc 0x1000,0x2000,0x3000 -> top 0x3004; pop x3 -> top 0x2004,0x1004,0, empty_o=1.
//  2 push 9 times with DEPTH=8 (pc 0x100*k) -> cnt=8; 8 pops return 0x904..0x204; 9th pop
//    -> underflow_o=1.
//  3 push 0x1000, then ctrl=11 with pc 0x5000 -> top 0x5004, cnt=1; ctrl=11 when empty -> push
//    + underflow_o=1.
//  4 capture ckpt (tos=2,cnt=2,top=0x2004); push x2, pop x3; recover_i with push same cycle
//    -> tos=2, cnt=2, top 0x2004, no push.
//  5 assert rst_i in the same cycle as a push and as a recover -> cnt=0, top_data_o=0,
//    underflow_o=0 next cycle.
//  6 ras_valid_i=0 with ctrl=01 for 10 cycles -> state unchanged; push pc 0xFFFF_FFFF_FFFF_FFFC
//    -> top wraps to 0.

Source files
------------

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Return address stack for the fetch stage. Keeps a circular
//                LIFO of predicted return targets, driven by the one-per-bundle
//                ras_ctrl/ras_data from the branch decoder. Exports the current
//                tos/occupancy/top as a per-bundle checkpoint and accepts a
//                restore of that checkpoint from execute on mispredict.
//  Ports       : clk_i, rst_i         clock, synchronous active-high reset
//                ras_valid_i          qualifies ras_ctrl_i
//                ras_ctrl_i           00 none, 01 push, 10 pop, 11 pop+push
//                ras_data_i           PC of the call/return instruction
//                recover_i            mispredict restore strobe
//                recover_tos_i/_cnt_i/_top_i  checkpoint being restored
//                top_data_o           predicted return target (mem[tos])
//                ckpt_tos_o/_cnt_o/_top_o     current (pre-update) checkpoint
//                empty_o              occupancy is zero
//                underflow_o          1-cycle pulse, pop applied while empty
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int AW    = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ras_valid_i,
    input  logic [1:0]       ras_ctrl_i,
    input  logic [AW-1:0]    ras_data_i,
    input  logic             recover_i,
    input  logic [PTR_W-1:0] recover_tos_i,
    input  logic [PTR_W:0]   recover_cnt_i,
    input  logic [AW-1:0]    recover_top_i,
    output logic [AW-1:0]    top_data_o,
    output logic [PTR_W-1:0] ckpt_tos_o,
    output logic [PTR_W:0]   ckpt_cnt_o,
    output logic [AW-1:0]    ckpt_top_o,
    output logic             empty_o,
    output logic             underflow_o
);

    localparam logic [1:0]     c_CTRL_PUSH    = 2'b01;
    localparam logic [1:0]     c_CTRL_POP     = 2'b10;
    localparam logic [1:0]     c_CTRL_POPPUSH = 2'b11;
    localparam logic [PTR_W:0] c_DEPTH_CNT    = (PTR_W+1)'(DEPTH);
    localparam logic [AW-1:0]  c_RET_OFS      = AW'(4);

    logic [AW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_tos;
    logic [PTR_W:0]   r_cnt;
    logic             r_underflow;

    logic [AW-1:0]    w_push_val;
    logic [PTR_W-1:0] w_tos_inc;
    logic [PTR_W-1:0] w_tos_dec;
    logic             w_empty;
    logic             w_full;
    logic [PTR_W:0]   w_rec_cnt;

    logic [PTR_W-1:0] w_tos_nxt;
    logic [PTR_W:0]   w_cnt_nxt;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_idx;
    logic [AW-1:0]    w_wr_data;
    logic             w_underflow_nxt;

    // Return target is the instruction after the call; carry out is dropped.
    assign w_push_val = ras_data_i + c_RET_OFS;
    assign w_tos_inc  = r_tos + PTR_W'(1);
    assign w_tos_dec  = r_tos - PTR_W'(1);
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == c_DEPTH_CNT);
    // An out-of-range restored occupancy is treated as a full stack.
    assign w_rec_cnt  = (recover_cnt_i > c_DEPTH_CNT) ? c_DEPTH_CNT : recover_cnt_i;

    always_comb begin
        w_tos_nxt       = r_tos;
        w_cnt_nxt       = r_cnt;
        w_wr_en         = 1'b0;
        w_wr_idx        = r_tos;
        w_wr_data       = w_push_val;
        w_underflow_nxt = 1'b0;
        if (recover_i) begin
            // Restore drops any same-cycle decoder operation.
            w_tos_nxt = recover_tos_i;
            w_cnt_nxt = w_rec_cnt;
            w_wr_en   = 1'b1;
            w_wr_idx  = recover_tos_i;
            w_wr_data = recover_top_i;
        end else if (ras_valid_i) begin
            case (ras_ctrl_i)
                c_CTRL_PUSH: begin
                    // When full, tos wraps onto the oldest entry and overwrites it.
                    w_tos_nxt = w_tos_inc;
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_tos_inc;
                    w_cnt_nxt = w_full ? r_cnt : r_cnt + (PTR_W+1)'(1);
                end
                c_CTRL_POP: begin
                    if (w_empty) begin
                        w_underflow_nxt = 1'b1;
                    end else begin
                        // Popped entry is left in place.
                        w_tos_nxt = w_tos_dec;
                        w_cnt_nxt = r_cnt - (PTR_W+1)'(1);
                    end
                end
                c_CTRL_POPPUSH: begin
                    if (w_empty) begin
                        // Nothing to pop: degrade to a plain push and flag it.
                        w_tos_nxt       = w_tos_inc;
                        w_wr_en         = 1'b1;
                        w_wr_idx        = w_tos_inc;
                        w_cnt_nxt       = r_cnt + (PTR_W+1)'(1);
                        w_underflow_nxt = 1'b1;
                    end else begin
                        // Replace the top in place; tos and occupancy unchanged.
                        w_wr_en  = 1'b1;
                        w_wr_idx = r_tos;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tos       <= '0;
            r_cnt       <= '0;
            r_underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_tos       <= w_tos_nxt;
            r_cnt       <= w_cnt_nxt;
            r_underflow <= w_underflow_nxt;
            if (w_wr_en) begin
                r_mem[w_wr_idx] <= w_wr_data;
            end
        end
    end

    assign top_data_o  = r_mem[r_tos];
    assign ckpt_top_o  = top_data_o;
    assign ckpt_tos_o  = r_tos;
    assign ckpt_cnt_o  = r_cnt;
    assign empty_o     = w_empty;
    assign underflow_o = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ras_stack
//  Description : Directed self-checking bench for ras_stack (DEPTH=8, AW=64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ras_stack;

    localparam logic [1:0] c_NONE    = 2'b00;
    localparam logic [1:0] c_PUSH    = 2'b01;
    localparam logic [1:0] c_POP     = 2'b10;
    localparam logic [1:0] c_POPPUSH = 2'b11;

    logic        clk;
    logic        rst;
    logic        ras_valid;
    logic [1:0]  ras_ctrl;
    logic [63:0] ras_data;
    logic        recover;
    logic [2:0]  recover_tos;
    logic [3:0]  recover_cnt;
    logic [63:0] recover_top;
    logic [63:0] top_data;
    logic [2:0]  ckpt_tos;
    logic [3:0]  ckpt_cnt;
    logic [63:0] ckpt_top;
    logic        empty;
    logic        underflow;

    int n_checks = 0;
    int n_errors = 0;

    ras_stack #(.DEPTH(8), .PTR_W(3), .AW(64)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ras_valid_i   (ras_valid),
        .ras_ctrl_i    (ras_ctrl),
        .ras_data_i    (ras_data),
        .recover_i     (recover),
        .recover_tos_i (recover_tos),
        .recover_cnt_i (recover_cnt),
        .recover_top_i (recover_top),
        .top_data_o    (top_data),
        .ckpt_tos_o    (ckpt_tos),
        .ckpt_cnt_o    (ckpt_cnt),
        .ckpt_top_o    (ckpt_top),
        .empty_o       (empty),
        .underflow_o   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] ctrl, input logic [63:0] pc);
        ras_valid = 1'b1;
        ras_ctrl  = ctrl;
        ras_data  = pc;
        tick();
        ras_valid = 1'b0;
        ras_ctrl  = c_NONE;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic state(input string tag, input logic [2:0] tos, input logic [3:0] cnt,
                         input logic [63:0] top);
        chk({tag, " tos"}, 64'(ckpt_tos), 64'(tos));
        chk({tag, " cnt"}, 64'(ckpt_cnt), 64'(cnt));
        chk({tag, " top"}, top_data, top);
        chk({tag, " ckpt_top"}, ckpt_top, top);
    endtask

    initial begin
        rst = 1'b1; ras_valid = 1'b0; ras_ctrl = c_NONE; ras_data = '0;
        recover = 1'b0; recover_tos = '0; recover_cnt = '0; recover_top = '0;
        tick();
        tick();
        rst = 1'b0;

        // 1: reset state, basic push/pop
        state("rst", 3'd0, 4'd0, 64'h0);
        chk("rst empty", 64'(empty), 64'd1);
        chk("rst uf", 64'(underflow), 64'd0);
        op(c_PUSH, 64'h1000);
        op(c_PUSH, 64'h2000);
        op(c_PUSH, 64'h3000);
        state("t1 push3", 3'd3, 4'd3, 64'h3004);
        chk("t1 not empty", 64'(empty), 64'd0);
        op(c_POP, '0);
        chk("t1 pop1", top_data, 64'h2004);
        op(c_POP, '0);
        chk("t1 pop2", top_data, 64'h1004);
        op(c_POP, '0);
        chk("t1 pop3", top_data, 64'h0);
        chk("t1 empty", 64'(empty), 64'd1);
        chk("t1 uf", 64'(underflow), 64'd0);

        // 2: overflow wraps onto oldest entry, then underflow
        for (int k = 1; k <= 9; k++) op(c_PUSH, 64'h100 * 64'(k));
        state("t2 full", 3'd1, 4'd8, 64'h904);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t2 popval%0d", i), top_data, 64'h904 - 64'h100 * 64'(i - 1));
            op(c_POP, '0);
        end
        chk("t2 drained empty", 64'(empty), 64'd1);
        chk("t2 drained uf", 64'(underflow), 64'd0);
        op(c_POP, '0);
        chk("t2 uf pulse", 64'(underflow), 64'd1);
        state("t2 uf state", 3'd1, 4'd0, 64'h904);
        tick();
        chk("t2 uf cleared", 64'(underflow), 64'd0);

        // 3: pop+push
        do_reset();
        op(c_PUSH, 64'h1000);
        op(c_POPPUSH, 64'h5000);
        state("t3 pp", 3'd1, 4'd1, 64'h5004);
        chk("t3 pp uf", 64'(underflow), 64'd0);
        op(c_POP, '0);
        chk("t3 empty", 64'(empty), 64'd1);
        op(c_POPPUSH, 64'h6000);
        state("t3 pp empty", 3'd1, 4'd1, 64'h6004);
        chk("t3 pp empty uf", 64'(underflow), 64'd1);

        // 4: checkpoint and recover
        do_reset();
        op(c_PUSH, 64'h1000);
        op(c_PUSH, 64'h2000);
        state("t4 ckpt", 3'd2, 4'd2, 64'h2004);
        op(c_PUSH, 64'h3000);
        op(c_PUSH, 64'h4000);
        op(c_POP, '0);
        op(c_POP, '0);
        op(c_POP, '0);
        state("t4 pre", 3'd1, 4'd1, 64'h1004);
        recover = 1'b1; recover_tos = 3'd2; recover_cnt = 4'd2; recover_top = 64'h2004;
        op(c_PUSH, 64'h7000);
        recover = 1'b0;
        state("t4 rec", 3'd2, 4'd2, 64'h2004);
        op(c_POP, '0);
        chk("t4 below", top_data, 64'h1004);
        recover = 1'b1; recover_tos = 3'd5; recover_cnt = 4'd12; recover_top = 64'hABC;
        tick();
        recover = 1'b0;
        state("t4 clamp", 3'd5, 4'd8, 64'hABC);
        recover = 1'b1; recover_tos = 3'd0; recover_cnt = 4'd0; recover_top = 64'h0;
        tick();
        chk("t4 rec empty", 64'(empty), 64'd1);
        op(c_POP, '0);
        recover = 1'b1;
        op(c_POP, '0);
        recover = 1'b0;
        chk("t4 rec uf", 64'(underflow), 64'd0);

        // 5: reset overrides push and recover
        op(c_PUSH, 64'h1000);
        rst = 1'b1;
        recover = 1'b1; recover_tos = 3'd4; recover_cnt = 4'd3; recover_top = 64'h55;
        op(c_PUSH, 64'h2000);
        recover = 1'b0;
        state("t5 rst", 3'd0, 4'd0, 64'h0);
        chk("t5 empty", 64'(empty), 64'd1);
        op(c_POP, '0);
        rst = 1'b0;
        chk("t5 rst uf", 64'(underflow), 64'd0);

        // 6: unqualified ctrl ignored; push value wraps
        op(c_PUSH, 64'h1000);
        ras_ctrl = c_PUSH; ras_data = 64'h9000;
        for (int i = 0; i < 10; i++) tick();
        ras_ctrl = c_NONE;
        state("t6 idle", 3'd1, 4'd1, 64'h1004);
        op(c_PUSH, 64'hFFFF_FFFF_FFFF_FFFC);
        state("t6 wrap", 3'd2, 4'd2, 64'h0);
        chk("t6 not empty", 64'(empty), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
